// File: rtl/sram_arb_ctrl.sv
// sram_arb_ctrl: parametrised single-port SRAM with two requesters and a
// power-on clear sequencer.
//   - Port A (CPU): 6116-style active-low strobes (a_cs_b/a_we_b/a_oe_b),
//     1-cycle read latency (a_dout/a_dout_vld), a_wait stalls a held access.
//   - Port B (video/DMA): read-only level req/ack handshake (b_req/b_addr ->
//     b_ack pulse with b_dout).
//   - Fixed priority to A; B is forced through after STARVE_MAX denied cycles.
//   - After reset every word is written with CLEAR_VAL (clr_busy high), one
//     word per cycle, before either port is served.
//   - Out-of-range addresses: writes dropped, reads return zero.
module sram_arb_ctrl #(
    parameter int unsigned      WIDTH      = 8,
    parameter int unsigned      DEPTH      = 2048,
    parameter int unsigned      ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter logic [WIDTH-1:0] CLEAR_VAL  = '0,
    parameter int unsigned      STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic [WIDTH-1:0]  a_din,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic              a_cs_b,
    input  logic              a_we_b,
    input  logic              a_oe_b,
    output logic [WIDTH-1:0]  a_dout,
    output logic              a_dout_vld,
    output logic              a_wait,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    output logic              b_ack,
    output logic [WIDTH-1:0]  b_dout,
    output logic              clr_busy
);

    localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [SW-1:0]     STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [WIDTH-1:0]  a_dout_q, a_dout_d;
    logic              a_vld_q, a_vld_d;
    logic [WIDTH-1:0]  b_dout_q, b_dout_d;
    logic              b_ack_q, b_ack_d;

    logic              run, a_wr, a_rd, a_act, b_grant, a_go;
    logic [WIDTH-1:0]  a_rdata, b_rdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [WIDTH-1:0]  mem_wd;

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return 32'(addr) < DEPTH;
    endfunction

    always_comb begin
        run   = (state_q == ST_RUN);
        a_wr  = ~a_cs_b & ~a_we_b;
        a_rd  = ~a_cs_b & ~a_oe_b & a_we_b;
        a_act = a_wr | a_rd;
        // B wins when A is idle or once B has been starved long enough.
        b_grant = run & b_req & (~a_act | (starve_q == STARVE_LIM));
        a_go    = run & a_act & ~b_grant;

        a_rdata = in_range(a_addr) ? mem[a_addr] : '0;
        b_rdata = in_range(b_addr) ? mem[b_addr] : '0;

        state_d = state_q;
        cnt_d   = cnt_q;
        if (!run) begin
            cnt_d = cnt_q + ADDR_W'(1);
            if (cnt_q == LAST_ADDR) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        end

        starve_d = starve_q;
        if (!run || !b_req || b_grant) begin
            starve_d = '0;
        end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + SW'(1);
        end

        a_vld_d  = 1'b0;
        a_dout_d = a_dout_q;
        if (a_go && a_rd) begin
            a_vld_d  = 1'b1;
            a_dout_d = a_rdata;
        end

        b_ack_d  = b_grant;
        b_dout_d = b_grant ? b_rdata : b_dout_q;

        mem_we = ~run | (a_go & a_wr & in_range(a_addr));
        mem_wa = run ? a_addr : cnt_q;
        mem_wd = run ? a_din : CLEAR_VAL;

        // Gated by rst_b so a_wait reads 0 in reset and makes a single clean
        // rise into the clear phase on release.
        a_wait = rst_b & (~run | (b_grant & a_act));
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= ST_CLEAR;
            cnt_q    <= '0;
            starve_q <= '0;
            a_dout_q <= '0;
            a_vld_q  <= 1'b0;
            b_dout_q <= '0;
            b_ack_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            a_dout_q <= a_dout_d;
            a_vld_q  <= a_vld_d;
            b_dout_q <= b_dout_d;
            b_ack_q  <= b_ack_d;
        end
    end

    // Array is not reset; the clear sequencer initialises it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    assign a_dout     = a_dout_q;
    assign a_dout_vld = a_vld_q;
    assign b_dout     = b_dout_q;
    assign b_ack      = b_ack_q;
    assign clr_busy   = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Testbench for sram_arb_ctrl: default instance (2048 words) plus a
// DEPTH=1500 instance sharing the same input stimulus.
module tb_sram_arb_ctrl;

    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rst_b;
    logic [7:0]  a_din;
    logic [10:0] a_addr;
    logic        a_cs_b, a_we_b, a_oe_b;
    logic        b_req;
    logic [10:0] b_addr;

    logic [7:0]  a_dout1, b_dout1, a_dout2, b_dout2;
    logic        a_vld1, a_wait1, b_ack1, clr_busy1;
    logic        a_vld2, a_wait2, b_ack2, clr_busy2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sram_arb_ctrl dut (
        .clk(clk), .rst_b(rst_b),
        .a_din(a_din), .a_addr(a_addr), .a_cs_b(a_cs_b), .a_we_b(a_we_b), .a_oe_b(a_oe_b),
        .a_dout(a_dout1), .a_dout_vld(a_vld1), .a_wait(a_wait1),
        .b_req(b_req), .b_addr(b_addr), .b_ack(b_ack1), .b_dout(b_dout1),
        .clr_busy(clr_busy1)
    );

    sram_arb_ctrl #(.DEPTH(1500)) dut2 (
        .clk(clk), .rst_b(rst_b),
        .a_din(a_din), .a_addr(a_addr), .a_cs_b(a_cs_b), .a_we_b(a_we_b), .a_oe_b(a_oe_b),
        .a_dout(a_dout2), .a_dout_vld(a_vld2), .a_wait(a_wait2),
        .b_req(b_req), .b_addr(b_addr), .b_ack(b_ack2), .b_dout(b_dout2),
        .clr_busy(clr_busy2)
    );

    typedef struct {
        logic        cs_b, we_b, oe_b;
        logic [10:0] addr;
        logic [7:0]  din;
        logic        breq;
        logic [10:0] baddr;
        logic        e_wait, e_vld;
        logic [7:0]  e_dout;
        logic        e_ack;
        logic [7:0]  e_bdout;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic cs, input logic we, input logic oe,
                                input logic [10:0] ad, input logic [7:0] d,
                                input logic br, input logic [10:0] ba,
                                input logic ew, input logic ev, input logic [7:0] ed,
                                input logic ea, input logic [7:0] ebd);
        vec_t v;
        v.cs_b = cs; v.we_b = we; v.oe_b = oe; v.addr = ad; v.din = d;
        v.breq = br; v.baddr = ba;
        v.e_wait = ew; v.e_vld = ev; v.e_dout = ed; v.e_ack = ea; v.e_bdout = ebd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drv(input logic cs, input logic we, input logic oe,
                       input logic [10:0] ad, input logic [7:0] d,
                       input logic br, input logic [10:0] ba);
        a_cs_b = cs; a_we_b = we; a_oe_b = oe; a_addr = ad; a_din = d;
        b_req = br; b_addr = ba;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] pick();
        case ($urandom_range(0, 4))
            0:       return 11'h123;
            1:       return 11'h050;
            2:       return 11'h640;
            3:       return 11'h7FF;
            default: return 11'h100 + 11'($urandom_range(0, 7));
        endcase
    endfunction

    // Behavioural reference state for the randomized phase.
    logic [7:0] mm [2048];
    int         starve;
    logic [7:0] e_dout, e_bdout;
    logic       e_vld, e_ack, e_wait;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int  n, n2;
        logic clr_err, b_seen;
        logic m_rd, m_wr, m_grant, hold_a, b_pend;

        rst_b = 1'b0;
        drv(1, 1, 1, 11'h0, 8'h0, 0, 11'h0);
        #3;
        chk("rst_a_dout", 32'(a_dout1), 32'h0);
        chk("rst_b_dout", 32'(b_dout1), 32'h0);
        chk("rst_vld",    32'(a_vld1), 32'h0);
        chk("rst_ack",    32'(b_ack1), 32'h0);
        chk("rst_wait",   32'(a_wait1), 32'h0);
        chk("rst_busy",   32'(clr_busy1), 32'h1);

        // Release, with A and B both requesting during the clear phase.
        @(negedge clk);
        rst_b = 1'b1;
        drv(0, 1, 0, 11'h7FF, 8'h0, 1, 11'h123);
        #1;
        chk("clr_wait_first", 32'(a_wait1), 32'h1);
        n = 0; n2 = 0; clr_err = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            n++;
            if (n2 == 0 && !clr_busy2) n2 = n;
            if (!clr_busy1) break;
            if (a_wait1 !== 1'b1 || a_vld1 !== 1'b0 || b_ack1 !== 1'b0) clr_err = 1'b1;
        end
        chk("clr_len",      32'(n), 32'd2048);
        chk("clr_len_1500", 32'(n2), 32'd1500);
        chk("clr_ports_ignored", 32'(clr_err), 32'h0);

        // Directed vectors (expected registered outputs are after the edge).
        tbl.push_back(mk(0,1,0,11'h7FF,8'h00, 0,11'h000, 0,1,8'h00,0,8'h00));
        tbl.push_back(mk(0,0,1,11'h123,8'h5A, 0,11'h000, 0,0,8'h00,0,8'h00));
        tbl.push_back(mk(0,1,0,11'h123,8'h00, 0,11'h000, 0,1,8'h5A,0,8'h00));
        tbl.push_back(mk(1,0,1,11'h123,8'h11, 0,11'h000, 0,0,8'h5A,0,8'h00));
        tbl.push_back(mk(0,1,0,11'h123,8'h00, 0,11'h000, 0,1,8'h5A,0,8'h00));
        tbl.push_back(mk(0,0,0,11'h050,8'h77, 0,11'h000, 0,0,8'h5A,0,8'h00));
        tbl.push_back(mk(0,1,0,11'h050,8'h00, 0,11'h000, 0,1,8'h77,0,8'h00));
        tbl.push_back(mk(1,1,1,11'h000,8'h00, 1,11'h123, 0,0,8'h77,1,8'h5A));
        tbl.push_back(mk(1,1,1,11'h000,8'h00, 1,11'h050, 0,0,8'h77,1,8'h77));
        tbl.push_back(mk(1,1,1,11'h000,8'h00, 1,11'h7FF, 0,0,8'h77,1,8'h00));
        tbl.push_back(mk(1,1,1,11'h000,8'h00, 1,11'h123, 0,0,8'h77,1,8'h5A));
        tbl.push_back(mk(1,1,1,11'h000,8'h00, 0,11'h000, 0,0,8'h77,0,8'h5A));
        foreach (tbl[i]) begin
            drv(tbl[i].cs_b, tbl[i].we_b, tbl[i].oe_b, tbl[i].addr, tbl[i].din,
                tbl[i].breq, tbl[i].baddr);
            #1;
            chk($sformatf("v%0d_wait", i), 32'(a_wait1), 32'(tbl[i].e_wait));
            tick();
            chk($sformatf("v%0d_vld", i),  32'(a_vld1),  32'(tbl[i].e_vld));
            chk($sformatf("v%0d_dout", i), 32'(a_dout1), 32'(tbl[i].e_dout));
            chk($sformatf("v%0d_ack", i),  32'(b_ack1),  32'(tbl[i].e_ack));
            chk($sformatf("v%0d_bdout", i),32'(b_dout1), 32'(tbl[i].e_bdout));
        end

        // Starvation: A reads every cycle, B held; B forced on the 5th cycle.
        drv(0, 1, 0, 11'h123, 8'h0, 1, 11'h050);
        for (int k = 1; k <= 6; k++) begin
            #1;
            chk($sformatf("stv%0d_wait", k), 32'(a_wait1), (k == 5) ? 32'h1 : 32'h0);
            tick();
            chk($sformatf("stv%0d_vld", k), 32'(a_vld1), (k == 5) ? 32'h0 : 32'h1);
            chk($sformatf("stv%0d_dout", k), 32'(a_dout1), 32'h5A);
            chk($sformatf("stv%0d_ack", k), 32'(b_ack1), (k == 5) ? 32'h1 : 32'h0);
            if (k == 5) begin
                chk("stv_bdout", 32'(b_dout1), 32'h77);
                b_req = 1'b0;
            end
        end
        drv(1, 1, 1, 11'h0, 8'h0, 0, 11'h0);
        tick();

        // Non-power-of-two depth: out-of-range access on the 1500-word copy.
        drv(0, 0, 1, 11'd1600, 8'hFF, 0, 11'h0);
        tick();
        drv(0, 1, 0, 11'd1600, 8'h00, 0, 11'h0);
        tick();
        chk("d1500_oor_vld",  32'(a_vld2), 32'h1);
        chk("d1500_oor_dout", 32'(a_dout2), 32'h00);
        chk("d2048_1600_dout", 32'(a_dout1), 32'hFF);
        drv(0, 1, 0, 11'h123, 8'h00, 0, 11'h0);
        tick();
        chk("d1500_123_dout", 32'(a_dout2), 32'h5A);
        drv(0, 1, 0, 11'd1499, 8'h00, 0, 11'h0);
        tick();
        chk("d1500_last_vld",  32'(a_vld2), 32'h1);
        chk("d1500_last_dout", 32'(a_dout2), 32'h00);
        drv(1, 1, 1, 11'h0, 8'h0, 1, 11'd1600);
        tick();
        chk("d1500_b_oor_ack",   32'(b_ack2), 32'h1);
        chk("d1500_b_oor_bdout", 32'(b_dout2), 32'h00);
        chk("d2048_b_1600",      32'(b_dout1), 32'hFF);
        drv(1, 1, 1, 11'h0, 8'h0, 0, 11'h0);
        tick();

        // Randomized traffic against the reference model (2048-word copy).
        for (int i = 0; i < 2048; i++) mm[i] = 8'h00;
        mm[11'h123] = 8'h5A; mm[11'h050] = 8'h77; mm[11'h640] = 8'hFF;
        starve = 0; e_dout = 8'h00; e_bdout = 8'hFF;
        hold_a = 1'b0; b_pend = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!hold_a) begin
                case ($urandom_range(0, 3))
                    0:       begin a_cs_b = 1; a_we_b = 1'($urandom); a_oe_b = 1'($urandom); end
                    1:       begin a_cs_b = 0; a_we_b = 1; a_oe_b = 0; end
                    2:       begin a_cs_b = 0; a_we_b = 0; a_oe_b = 1'($urandom); end
                    default: begin a_cs_b = 0; a_we_b = 1; a_oe_b = 1; end
                endcase
                a_addr = pick();
                a_din  = 8'($urandom);
            end
            if (!b_pend) begin
                b_req  = ($urandom_range(0, 2) == 0);
                b_addr = pick();
            end
            m_rd = !a_cs_b && !a_oe_b && a_we_b;
            m_wr = !a_cs_b && !a_we_b;
            m_grant = b_req && (!(m_rd || m_wr) || starve == SMAX);
            e_wait  = m_grant && (m_rd || m_wr);
            #1;
            chk("rnd_wait", 32'(a_wait1), 32'(e_wait));
            e_ack = m_grant;
            if (m_grant) e_bdout = mm[b_addr];
            e_vld = 1'b0;
            if (!e_wait && m_rd) begin
                e_vld  = 1'b1;
                e_dout = mm[a_addr];
            end
            if (!e_wait && m_wr) mm[a_addr] = a_din;
            if (!b_req || m_grant) starve = 0;
            else if (starve < SMAX) starve++;
            tick();
            chk("rnd_vld",   32'(a_vld1),  32'(e_vld));
            chk("rnd_dout",  32'(a_dout1), 32'(e_dout));
            chk("rnd_ack",   32'(b_ack1),  32'(e_ack));
            chk("rnd_bdout", 32'(b_dout1), 32'(e_bdout));
            hold_a = e_wait;
            b_pend = b_req && !m_grant;
        end

        // Mid-RUN reset with a B request pending: no ack, outputs cleared.
        drv(1, 1, 1, 11'h0, 8'h0, 1, 11'h123);
        #1;
        rst_b = 1'b0;
        #1;
        chk("rst2_a_dout", 32'(a_dout1), 32'h0);
        chk("rst2_b_dout", 32'(b_dout1), 32'h0);
        chk("rst2_ack",    32'(b_ack1), 32'h0);
        chk("rst2_wait",   32'(a_wait1), 32'h0);
        chk("rst2_busy",   32'(clr_busy1), 32'h1);
        b_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (b_ack1 !== 1'b0) b_seen = 1'b1;
        end
        b_req = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        clr_err = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (b_ack1 !== 1'b0) b_seen = 1'b1;
            if (clr_busy1 !== 1'b1) clr_err = 1'b1;
        end
        chk("rst2_no_ack", 32'(b_seen), 32'h0);
        chk("clr100_busy", 32'(clr_err), 32'h0);
        rst_b = 1'b0;
        #2;
        chk("pulse_busy", 32'(clr_busy1), 32'h1);
        @(negedge clk);
        rst_b = 1'b1;
        n = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            n++;
            if (!clr_busy1) break;
        end
        chk("clr_restart_len", 32'(n), 32'd2048);
        drv(0, 1, 0, 11'h123, 8'h0, 0, 11'h0);
        tick();
        chk("post_clr_vld",  32'(a_vld1), 32'h1);
        chk("post_clr_dout", 32'(a_dout1), 32'h00);
        drv(1, 1, 1, 11'h0, 8'h0, 0, 11'h0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
